// File: rtl/gate_stim_pkg.sv
// Shared types and default timing constants for the gate stimulus generator.
package gate_stim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_e;

    localparam int DEF_TICK_DIV  = 50;
    localparam int DEF_RUN_TICKS = 20;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
import gate_stim_pkg::*;

module tick_prescaler #(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign tick = en && !clr && (cnt_q == 16'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gate_stim_gen.sv
// Drives a/b/c stimulus patterns per tick and counts gate responses.
// Define GATE_STIM_CHECK_EN to enable the sticky d_in vs (a|b|c) checker.
import gate_stim_pkg::*;

module gate_stim_gen #(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int RUN_TICKS = DEF_RUN_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       d_in,
    input  logic       e_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] d_ones,
    output logic [7:0] e_ones,
    output logic       err
);

    state_e      state_q, state_d;
    logic        a_q, a_d, b_q, b_d, c_q, c_d;
    logic [7:0]  d_ones_q, d_ones_d, e_ones_q, e_ones_d;
    logic [7:0]  tick_cnt_q, tick_cnt_d;
    logic [1:0]  mod3_q, mod3_d;
    logic        launch;
    logic        tick;

    assign launch = (state_q == IDLE) && start && !stop;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == RUN),
        .clr   (launch),
        .tick  (tick)
    );

`ifdef GATE_STIM_CHECK_EN
    logic err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        d_ones_d   = d_ones_q;
        e_ones_d   = e_ones_q;
        tick_cnt_d = tick_cnt_q;
        mod3_d     = mod3_q;
`ifdef GATE_STIM_CHECK_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d    = RUN;
                    a_d        = 1'b0;
                    b_d        = 1'b0;
                    c_d        = 1'b0;
                    d_ones_d   = '0;
                    e_ones_d   = '0;
                    tick_cnt_d = '0;
                    mod3_d     = '0;
`ifdef GATE_STIM_CHECK_EN
                    err_d      = 1'b0;
`endif
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    c_d     = 1'b0;
                end else if (tick) begin
                    // tick_cnt_q holds n-1, so an odd value means n is even
                    if (d_in && d_ones_q != 8'hFF) d_ones_d = d_ones_q + 8'd1;
                    if (e_in && e_ones_q != 8'hFF) e_ones_d = e_ones_q + 8'd1;
`ifdef GATE_STIM_CHECK_EN
                    if (d_in != (a_q | b_q | c_q)) err_d = 1'b1;
`endif
                    a_d        = ~a_q;
                    b_d        = b_q ^ tick_cnt_q[0];
                    c_d        = c_q ^ (mod3_q == 2'd2);
                    mod3_d     = (mod3_q == 2'd2) ? 2'd0 : mod3_q + 2'd1;
                    tick_cnt_d = tick_cnt_q + 8'd1;
                    if (tick_cnt_q == 8'(RUN_TICKS - 1)) state_d = FIN;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            c_q        <= 1'b0;
            d_ones_q   <= '0;
            e_ones_q   <= '0;
            tick_cnt_q <= '0;
            mod3_q     <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_ones_q   <= d_ones_d;
            e_ones_q   <= e_ones_d;
            tick_cnt_q <= tick_cnt_d;
            mod3_q     <= mod3_d;
        end
    end

`ifdef GATE_STIM_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    assign a      = a_q;
    assign b      = b_q;
    assign c      = c_q;
    assign d_ones = d_ones_q;
    assign e_ones = e_ones_q;
    assign busy   = (state_q == RUN);
    assign done   = (state_q == FIN);

endmodule

// File: tb/tb_gate_stim_gen.sv
// Bench for gate_stim_gen: random inputs against a tick-count reference model.
module tb_gate_stim_gen;

    localparam int TD = 2;
    localparam int RT = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       d_rand = 1'b0;
    logic       e_rand = 1'b0;
    logic       d_in, e_in;
    logic       a, b, c, busy, done, err;
    logic [7:0] d_ones, e_ones;

    int total = 0;
    int bad = 0;
    int mode = 0;

    // model state
    bit m_run = 0, m_fin = 0, m_zero = 1, m_err = 0;
    int m_cyc = 0, m_k = 0, m_d = 0, m_e = 0;
    int bc, dc;

    assign d_in = (mode == 1) ? (a | b | c) : (mode == 2) ? 1'b0 : d_rand;
    assign e_in = e_rand;

    always #5 clk = ~clk;

    gate_stim_gen #(
        .TICK_DIV  (TD),
        .RUN_TICKS (RT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .a      (a),
        .b      (b),
        .c      (c),
        .d_in   (d_in),
        .e_in   (e_in),
        .busy   (busy),
        .done   (done),
        .d_ones (d_ones),
        .e_ones (e_ones),
        .err    (err)
    );

    // after k ticks: a = k mod 2, b toggled floor(k/2) times, c floor(k/3)
    function automatic bit ea(int k); return bit'(k % 2); endfunction
    function automatic bit eb(int k); return bit'((k / 2) % 2); endfunction
    function automatic bit ec(int k); return bit'((k / 3) % 2); endfunction

    function automatic bit exp_err();
`ifdef GATE_STIM_CHECK_EN
        return m_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit pre;
        pre = m_zero;
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_fin));
        chk("a", 32'(a), pre ? 0 : 32'(ea(m_k)));
        chk("b", 32'(b), pre ? 0 : 32'(eb(m_k)));
        chk("c", 32'(c), pre ? 0 : 32'(ec(m_k)));
        chk("d_ones", 32'(d_ones), 32'(m_d));
        chk("e_ones", 32'(e_ones), 32'(m_e));
        chk("err", 32'(err), 32'(exp_err()));
    endtask

    task automatic step(input bit st, input bit sp, input bit r);
        bit sd, se;
        @(negedge clk);
        rst_n  = r;
        start  = st;
        stop   = sp;
        d_rand = 1'($urandom);
        e_rand = 1'($urandom);
        #1;
        sd = d_in;
        se = e_in;
        @(posedge clk);
        if (!r) begin
            m_run = 0; m_fin = 0; m_k = 0; m_zero = 1;
            m_d = 0; m_e = 0; m_err = 0;
        end else if (m_run) begin
            if (sp) begin
                m_run = 0;
                m_zero = 1;
            end else begin
                m_cyc++;
                if (m_cyc % TD == 0) begin
                    if (sd != (ea(m_k) | eb(m_k) | ec(m_k))) m_err = 1;
                    if (sd && m_d < 255) m_d++;
                    if (se && m_e < 255) m_e++;
                    m_k++;
                    if (m_k == RT) begin
                        m_run = 0;
                        m_fin = 1;
                    end
                end
            end
        end else if (m_fin) begin
            m_fin = 0;
        end else if (st && !sp) begin
            m_run = 1; m_cyc = 0; m_k = 0; m_zero = 0;
            m_d = 0; m_e = 0; m_err = 0;
        end
        #1;
        check_all();
    endtask

    // start is randomly re-asserted only where it must be ignored
    task automatic auto(input int n);
        for (int i = 0; i < n; i++) begin
            step((m_run || m_fin) ? 1'($urandom) : 1'b0, 1'b0, 1'b1);
            bc += int'(busy);
            dc += int'(done);
        end
    endtask

    initial begin
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);

        mode = 0;
        step(1, 0, 1);
        bc = int'(busy);
        dc = 0;
        auto(14);
        chk("busy_len", 32'(bc), 12);
        chk("done_len", 32'(dc), 1);
        chk("fin_a", 32'(a), 0);
        chk("fin_b", 32'(b), 1);
        chk("fin_c", 32'(c), 0);

        mode = 1;
        step(1, 0, 1);
        auto(14);
        chk("loop_d_ones", 32'(d_ones), 5);
        chk("loop_err", 32'(err), 0);

        mode = 2;
        step(1, 0, 1);
        auto(2);
        chk("fault_err_t1", 32'(err), 0);
        auto(2);
`ifdef GATE_STIM_CHECK_EN
        chk("fault_err_t2", 32'(err), 1);
`else
        chk("fault_err_t2", 32'(err), 0);
`endif
        auto(10);
`ifdef GATE_STIM_CHECK_EN
        chk("fault_err_end", 32'(err), 1);
`else
        chk("fault_err_end", 32'(err), 0);
`endif
        mode = 0;

        step(1, 0, 1);
        auto(5);
        step(0, 1, 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_abc", 32'({a, b, c}), 0);
        step(0, 0, 1);
        chk("abort_nodone", 32'(done), 0);

        step(1, 1, 1);
        chk("ss_idle", 32'(busy), 0);
        step(0, 0, 1);

        step(1, 0, 1);
        auto(5);
        step(0, 0, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outs", 32'({a, b, c, done, err}), 0);
        chk("rst_ones", 32'({d_ones, e_ones}), 0);
        step(1, 0, 1);
        bc = int'(busy);
        dc = 0;
        auto(14);
        chk("rerun_busy_len", 32'(bc), 12);
        chk("rerun_done_len", 32'(dc), 1);
        chk("rerun_abc", 32'({a, b, c}), 32'(3'b010));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_stim_gen.md
GATE_STIM_GEN -- requirements
Module: gate_stim_gen

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50, meaning clk cycles per stimulus tick (legal 2..65535).
REQ-002 SHALL have parameter RUN_TICKS, default 20, meaning ticks per run (legal 1..255).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1, run request, sampled each cycle.
REQ-006 SHALL have port stop, input, 1, abort request, sampled each cycle.
REQ-007 SHALL have ports a, b, c, output, 1 each, stimulus drives for the gate under test.
REQ-008 SHALL have ports d_in, e_in, input, 1 each, gate results to be observed.
REQ-009 SHALL have port busy, output, 1, high while running.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at normal run completion.
REQ-011 SHALL have ports d_ones, e_ones, output, 8 each, count of ticks on which d_in / e_in sampled high.
REQ-012 SHALL have port err, output, 1, sticky mismatch flag (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIN; IDLE->RUN on start, RUN->FIN after tick RUN_TICKS, RUN->IDLE on stop, FIN->IDLE unconditionally after one cycle.
REQ-014 SHALL, on IDLE->RUN, clear a, b, c, d_ones, e_ones, err, the prescaler, and the tick counter in the same edge.
REQ-015 SHALL generate a tick on the cycle the prescaler reaches TICK_DIV-1, then wrap it to 0; the prescaler counts only in RUN.
REQ-016 SHALL number ticks 1..RUN_TICKS; on tick n: a toggles, b toggles if n mod 2 = 0, c toggles if n mod 3 = 0.
REQ-017 SHALL, on each tick, sample d_in and e_in before that tick's toggle takes effect, and increment d_ones / e_ones if high, saturating at 255.
REQ-018 SHALL make the first tick occur TICK_DIV cycles after the start edge; the RUN->FIN transition is on tick RUN_TICKS; run length is RUN_TICKS*TICK_DIV cycles.
REQ-019 SHALL assert busy exactly in RUN and done exactly in FIN.
REQ-020 SHALL ignore start while in RUN or FIN.
REQ-021 SHALL give stop priority over start and over a coincident final tick: return to IDLE, clear a/b/c to 0, no done pulse, and hold d_ones/e_ones.
REQ-022 SHALL hold a, b, c, d_ones, e_ones, err in FIN and IDLE after normal completion.

Reset
REQ-023 SHALL, when rst_n is low at a clk edge, enter IDLE and force a=b=c=0, busy=0, done=0, d_ones=e_ones=0, err=0, prescaler=0, tick counter=0.
REQ-024 SHALL let reset mid-run abort immediately with no done pulse.

Configuration
REQ-025 SHALL use macro GATE_STIM_CHECK_EN: when defined, on each tick set err if d_in != (a|b|c) as driven before the toggle.
REQ-026 SHALL tie err to constant 0 when GATE_STIM_CHECK_EN is undefined, with no checker logic synthesized.

Structure
REQ-027 SHALL place the FSM state enum (IDLE/RUN/FIN) and the default TICK_DIV/RUN_TICKS constants in package gate_stim_pkg.
REQ-028 SHALL implement the prescaler as sub-module tick_prescaler (inputs clk, rst_n, en, clr; output tick).

Verification
REQ-029 SHALL cover basic run: TICK_DIV=2, RUN_TICKS=6, start pulse -> busy for 12 cycles, then done for 1 cycle, final a=0, b=1, c=0.
REQ-030 SHALL cover OR-gate loopback: d_in=a|b|c, TICK_DIV=2, RUN_TICKS=6 -> d_ones=5 and err=0 with macro defined.
REQ-031 SHALL cover forced fault: d_in tied 0, macro defined -> err=1 after the first tick on which a|b|c=1 (tick 2) and stays 1; macro undefined -> err=0.
REQ-032 SHALL cover abort: stop asserted at tick 3 -> IDLE next edge, a=b=c=0, no done, d_ones held.
REQ-033 SHALL cover start re-issued mid-run and start+stop in the same cycle from IDLE -> start ignored / remains IDLE.
REQ-034 SHALL cover rst_n low mid-run for 1 cycle -> all outputs 0 at the next edge, then a fresh start completes normally.
